// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit.
// Covers opcodes, function fields, FSM states, ALU codes and decoded instruction classes.
package mips_pkg;

  typedef enum logic [2:0] {
    S_IF  = 3'b000,
    S_ID  = 3'b001,
    S_EXE = 3'b010,
    S_MEM = 3'b011,
    S_WB  = 3'b100
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_HAMM = 6'b110000;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0100;
  localparam logic [3:0] ALU_AND  = 4'b0001;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0010;
  localparam logic [3:0] ALU_LUI  = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1111;
  localparam logic [3:0] ALU_HAMM = 4'b1011;

  // One-hot instruction class; all-zero means unsupported (runs as a NOP).
  typedef struct packed {
    logic r_alu;
    logic r_shift;
    logic i_alu;
    logic i_addi;
    logic lw;
    logic sw;
    logic beq;
    logic bne;
    logic j;
    logic jal;
    logic jr;
  } iclass_t;

endpackage

// File: rtl/mc_dec.sv
// Combinational instruction decoder for mc_cu.
// Maps op/func to a one-hot instruction class plus the ALU operation code.
module mc_dec
  import mips_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output iclass_t    cls,
  output logic [3:0] aluc
);

  always_comb begin
    cls  = '0;
    aluc = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        case (func)
          FN_ADD:  begin cls.r_alu   = 1'b1; aluc = ALU_ADD;  end
          FN_SUB:  begin cls.r_alu   = 1'b1; aluc = ALU_SUB;  end
          FN_AND:  begin cls.r_alu   = 1'b1; aluc = ALU_AND;  end
          FN_OR:   begin cls.r_alu   = 1'b1; aluc = ALU_OR;   end
          FN_XOR:  begin cls.r_alu   = 1'b1; aluc = ALU_XOR;  end
          FN_HAMM: begin cls.r_alu   = 1'b1; aluc = ALU_HAMM; end
          FN_SLL:  begin cls.r_shift = 1'b1; aluc = ALU_SLL;  end
          FN_SRL:  begin cls.r_shift = 1'b1; aluc = ALU_SRL;  end
          FN_SRA:  begin cls.r_shift = 1'b1; aluc = ALU_SRA;  end
          FN_JR:   cls.jr = 1'b1;
          default: ;
        endcase
      end
      OP_ADDI: begin cls.i_addi = 1'b1; aluc = ALU_ADD; end
      OP_ANDI: begin cls.i_alu  = 1'b1; aluc = ALU_AND; end
      OP_ORI:  begin cls.i_alu  = 1'b1; aluc = ALU_OR;  end
      OP_XORI: begin cls.i_alu  = 1'b1; aluc = ALU_XOR; end
      OP_LUI:  begin cls.i_alu  = 1'b1; aluc = ALU_LUI; end
      OP_LW:   cls.lw  = 1'b1;
      OP_SW:   cls.sw  = 1'b1;
      OP_BEQ:  begin cls.beq = 1'b1; aluc = ALU_SUB; end
      OP_BNE:  begin cls.bne = 1'b1; aluc = ALU_SUB; end
      OP_J:    cls.j   = 1'b1;
      OP_JAL:  cls.jal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_cu.sv
// Multi-cycle MIPS control unit: state register, next-state and output logic.
// Write enables are gated by resetn so a reset cycle never commits state.
module mc_cu
  import mips_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       z,
  output logic       wpc,
  output logic       wir,
  output logic       wmem,
  output logic       wreg,
  output logic       iord,
  output logic       regrt,
  output logic       m2reg,
  output logic       jal,
  output logic [3:0] aluc,
  output logic       shift,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       sext,
  output logic [1:0] pcsource,
  output logic [2:0] state
);

  state_t     cur_state, next_state;
  iclass_t    cls;
  logic [3:0] dec_aluc;
  logic       wpc_c, wir_c, wmem_c, wreg_c;

  mc_dec u_dec (
    .op   (op),
    .func (func),
    .cls  (cls),
    .aluc (dec_aluc)
  );

  always_ff @(posedge clock) begin
    if (!resetn) cur_state <= S_IF;
    else         cur_state <= next_state;
  end

  always_comb begin
    next_state = S_IF;
    wpc_c      = 1'b0;
    wir_c      = 1'b0;
    wmem_c     = 1'b0;
    wreg_c     = 1'b0;
    iord       = 1'b0;
    regrt      = 1'b0;
    m2reg      = 1'b0;
    jal        = 1'b0;
    aluc       = ALU_ADD;
    shift      = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    sext       = 1'b0;
    pcsource   = 2'b00;
    case (cur_state)
      S_IF: begin
        wpc_c      = 1'b1;
        wir_c      = 1'b1;
        alusrcb    = 2'b01;
        next_state = S_ID;
      end
      S_ID: begin
        // Branch target is precomputed here for every instruction.
        alusrcb = 2'b11;
        sext    = 1'b1;
        if (cls.j) begin
          wpc_c    = 1'b1;
          pcsource = 2'b11;
        end else if (cls.jal) begin
          wpc_c    = 1'b1;
          pcsource = 2'b11;
          wreg_c   = 1'b1;
          jal      = 1'b1;
        end else if (cls.jr) begin
          wpc_c    = 1'b1;
          pcsource = 2'b10;
        end else if (cls != '0) begin
          next_state = S_EXE;
        end
      end
      S_EXE: begin
        alusrca = 1'b1;
        if (cls.beq || cls.bne) begin
          aluc     = ALU_SUB;
          pcsource = 2'b01;
          wpc_c    = (cls.beq & z) | (cls.bne & ~z);
        end else if (cls.lw || cls.sw) begin
          alusrcb    = 2'b10;
          sext       = 1'b1;
          next_state = S_MEM;
        end else if (cls.r_alu || cls.r_shift) begin
          aluc       = dec_aluc;
          shift      = cls.r_shift;
          next_state = S_WB;
        end else if (cls.i_alu || cls.i_addi) begin
          aluc       = dec_aluc;
          alusrcb    = 2'b10;
          sext       = cls.i_addi;
          next_state = S_WB;
        end
      end
      S_MEM: begin
        iord = 1'b1;
        if (cls.lw)      next_state = S_WB;
        else if (cls.sw) wmem_c     = 1'b1;
      end
      S_WB: begin
        wreg_c = 1'b1;
        m2reg  = cls.lw;
        regrt  = cls.lw | cls.i_alu | cls.i_addi;
      end
      default: next_state = S_IF;
    endcase
  end

  assign wpc   = wpc_c  & resetn;
  assign wir   = wir_c  & resetn;
  assign wmem  = wmem_c & resetn;
  assign wreg  = wreg_c & resetn;
  assign state = cur_state;

endmodule
